// File: rtl/ub_pkg.sv
// ---------------------------------------------------------------------------
// ub_pkg
//   Shared types and constants for the unified-buffer read scheduler.
//   - ub_sched_state_t : scheduler FSM encoding (IDLE / ISSUE / WAIT)
//   - UB_ADDR_W        : width of unified-buffer addresses and burst lengths
//   - UB_DEPTH_DEFAULT : default number of 16-bit buffer locations
//   - ub_len_legal     : burst length is even and non-zero
//   - ub_in_bounds     : burst end (addr + num) fits inside the buffer,
//                        evaluated one bit wider than an address so it
//                        cannot wrap
// ---------------------------------------------------------------------------
package ub_pkg;

  localparam int UB_ADDR_W        = 6;
  localparam int UB_DEPTH_DEFAULT = 50;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } ub_sched_state_t;

  // The buffer streams two words per cycle after a single lead word, so a
  // burst must cover an even, non-zero number of locations.
  function automatic logic ub_len_legal(input logic [UB_ADDR_W-1:0] num);
    return (num[0] == 1'b0) && (num != '0);
  endfunction

  function automatic logic ub_in_bounds(input logic [UB_ADDR_W-1:0] addr,
                                        input logic [UB_ADDR_W-1:0] num,
                                        input int                   depth);
    logic [UB_ADDR_W:0] end_addr;
    end_addr = {1'b0, addr} + {1'b0, num};
    return end_addr <= (UB_ADDR_W+1)'(depth);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter. A lone valid requester always wins; when
//   both are valid the one that was not granted last wins. The history bit
//   only advances when the caller reports a completed handshake, so a grant
//   that is not taken does not rotate priority.
//
//   Ports
//     clk        : clock
//     rst        : asynchronous active-high reset (history -> requester 1,
//                  so requester 0 wins the first tie)
//     valid      : per-requester request
//     update     : a handshake with the current winner happens this cycle
//     grant      : one-hot (or zero) combinational grant
//     winner     : index of the granted requester (meaningful when grant!=0)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant,
  output logic       winner
);

  logic last_grant_reg;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign winner = grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (update) begin
      last_grant_reg <= winner;
    end
  end

endmodule

// File: rtl/ub_read_scheduler.sv
// ---------------------------------------------------------------------------
// ub_read_scheduler
//   Shares the unified-buffer read port between the systolic-array loader
//   (requester 0) and the vector-unit operand fetch (requester 1). Commands
//   arrive over valid/ready, are arbitrated round-robin, and each legal one
//   produces a single-cycle read-start pulse. The scheduler then waits out
//   the buffer's burst so the next start only lands when the buffer read
//   FSM is idle again.
//
//   Burst schedule for a handshake in cycle H with length num:
//     H+1              ISSUE : start pulse with address/length/row-col
//     H+2 .. H+1+num/2 WAIT  : buffer streams the burst
//     H+2+num/2        IDLE  : done pulse for the owner; buffer is idle,
//                              so a new handshake may occur here
//
//   Illegal commands (odd or zero length) are consumed in IDLE and answered
//   with an err pulse one cycle later; no start is issued.
//
//   Optional feature (macro UB_SCHED_BOUNDS_CHECK_EN):
//     when defined, a command whose addr + num exceeds UB_DEPTH is also
//     rejected with an err pulse. When undefined such commands are issued
//     unchanged.
//
//   Ports
//     clk, rst                   : clock, asynchronous active-high reset
//     req_valid_in / ready_out   : per-requester command handshake
//     req_addr_in, req_num_in    : per-requester start address, length
//     req_row_or_col_in          : per-requester row/col select
//     ub_read_start_out          : one-cycle read start to the buffer
//     ub_read_addr_out           : burst start address (held between bursts)
//     ub_num_mem_locations_out   : burst length (held between bursts)
//     ub_row_or_col_out          : row/col select (held between bursts)
//     owner_out                  : requester owning the current burst
//     busy_out                   : scheduler is not IDLE
//     done_out                   : per-requester burst-complete pulse
//     err_out                    : per-requester command-rejected pulse
// ---------------------------------------------------------------------------
import ub_pkg::*;

module ub_read_scheduler #(
  parameter int UB_DEPTH = UB_DEPTH_DEFAULT,
  parameter int NUM_REQ  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  input  logic [NUM_REQ-1:0][UB_ADDR_W-1:0]  req_addr_in,
  input  logic [NUM_REQ-1:0][UB_ADDR_W-1:0]  req_num_in,
  input  logic [NUM_REQ-1:0]                 req_row_or_col_in,
  output logic                               ub_read_start_out,
  output logic [UB_ADDR_W-1:0]               ub_read_addr_out,
  output logic [UB_ADDR_W-1:0]               ub_num_mem_locations_out,
  output logic                               ub_row_or_col_out,
  output logic                               owner_out,
  output logic                               busy_out,
  output logic [NUM_REQ-1:0]                 done_out,
  output logic [NUM_REQ-1:0]                 err_out
);

  // The arbiter and the one-bit owner are two-way only; catch a bad
  // configuration at elaboration rather than in silicon.
  if (NUM_REQ != 2) begin : g_bad_num_req
    $error("ub_read_scheduler supports exactly two requesters");
  end
  if (UB_DEPTH < 2 || UB_DEPTH > (1 << UB_ADDR_W)) begin : g_bad_depth
    $error("UB_DEPTH must fit the unified-buffer address space");
  end

  ub_sched_state_t               state_reg;
  logic [UB_ADDR_W-2:0]          cnt_reg;
  logic                          start_reg;
  logic [UB_ADDR_W-1:0]          addr_reg;
  logic [UB_ADDR_W-1:0]          num_reg;
  logic                          row_or_col_reg;
  logic                          owner_reg;
  logic [NUM_REQ-1:0]            done_reg;
  logic [NUM_REQ-1:0]            err_reg;

  logic [NUM_REQ-1:0]            grant;
  logic                          winner;
  logic                          idle;
  logic                          handshake;
  logic [UB_ADDR_W-1:0]          sel_addr;
  logic [UB_ADDR_W-1:0]          sel_num;
  logic                          sel_row_or_col;
  logic                          cmd_legal;

  assign idle = (state_reg == IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid_in),
    .update (handshake),
    .grant  (grant),
    .winner (winner)
  );

  // Only the arbitration winner sees ready, and only while IDLE.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready_out[gi] = idle & grant[gi];
    end
  endgenerate

  assign handshake      = |(req_valid_in & req_ready_out);
  assign sel_addr       = req_addr_in[winner];
  assign sel_num        = req_num_in[winner];
  assign sel_row_or_col = req_row_or_col_in[winner];

  always_comb begin
    cmd_legal = ub_len_legal(sel_num);
`ifdef UB_SCHED_BOUNDS_CHECK_EN
    cmd_legal = cmd_legal & ub_in_bounds(sel_addr, sel_num, UB_DEPTH);
`endif
  end

  // Burst FSM. Payload registers only load for a legal command so the
  // buffer-facing address/length/row-col hold the last issued burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      start_reg      <= 1'b0;
      addr_reg       <= '0;
      num_reg        <= '0;
      row_or_col_reg <= 1'b0;
      owner_reg      <= 1'b0;
      done_reg       <= '0;
      err_reg        <= '0;
    end else begin
      start_reg <= 1'b0;
      done_reg  <= '0;
      err_reg   <= '0;
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            if (cmd_legal) begin
              addr_reg       <= sel_addr;
              num_reg        <= sel_num;
              row_or_col_reg <= sel_row_or_col;
              owner_reg      <= winner;
              start_reg      <= 1'b1;
              state_reg      <= ISSUE;
            end else begin
              err_reg[winner] <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // One WAIT cycle per word pair; the lead word and the trailing
          // lane-2 word together account for the final pair.
          cnt_reg   <= num_reg[UB_ADDR_W-1:1];
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg <= (UB_ADDR_W-1)'(1)) begin
            cnt_reg             <= '0;
            done_reg[owner_reg] <= 1'b1;
            state_reg           <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - (UB_ADDR_W-1)'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ub_read_start_out        = start_reg;
  assign ub_read_addr_out         = addr_reg;
  assign ub_num_mem_locations_out = num_reg;
  assign ub_row_or_col_out        = row_or_col_reg;
  assign owner_out                = owner_reg;
  assign busy_out                 = ~idle;
  assign done_out                 = done_reg;
  assign err_out                  = err_reg;

endmodule

// File: tb/tb_ub_read_scheduler.sv
`timescale 1ns/1ps
module tb_ub_read_scheduler;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid_in = 2'b00;
  logic [1:0]      req_ready_out;
  logic [1:0][5:0] req_addr_in = '0;
  logic [1:0][5:0] req_num_in = '0;
  logic [1:0]      req_row_or_col_in = 2'b00;
  logic            ub_read_start_out;
  logic [5:0]      ub_read_addr_out;
  logic [5:0]      ub_num_mem_locations_out;
  logic            ub_row_or_col_out;
  logic            owner_out;
  logic            busy_out;
  logic [1:0]      done_out;
  logic [1:0]      err_out;

  ub_read_scheduler dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid_in             (req_valid_in),
    .req_ready_out            (req_ready_out),
    .req_addr_in              (req_addr_in),
    .req_num_in               (req_num_in),
    .req_row_or_col_in        (req_row_or_col_in),
    .ub_read_start_out        (ub_read_start_out),
    .ub_read_addr_out         (ub_read_addr_out),
    .ub_num_mem_locations_out (ub_num_mem_locations_out),
    .ub_row_or_col_out        (ub_row_or_col_out),
    .owner_out                (owner_out),
    .busy_out                 (busy_out),
    .done_out                 (done_out),
    .err_out                  (err_out)
  );

  always #5 clk = ~clk;

  // cyc names the interval after each rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] addr;
    logic [5:0] num;
    logic       rc;
    logic       own;
    int         scyc;
    int         dcyc;
  } burst_t;

  typedef struct {
    logic own;
    int   ecyc;
  } err_t;

  burst_t start_q[$];
  burst_t done_q[$];
  err_t   err_q[$];
  logic   lg = 1'b1;
  int     checks = 0;
  int     errors = 0;

  function automatic logic model_legal(input logic [5:0] a, input logic [5:0] n);
    logic ok;
    ok = (n[0] == 1'b0) && (n != 6'd0);
`ifdef UB_SCHED_BOUNDS_CHECK_EN
    if (({1'b0, a} + {1'b0, n}) > 7'd50) ok = 1'b0;
`else
    if (a == 6'h3f && n == 6'h3f) ok = ok;  // address unchecked in this build
`endif
    return ok;
  endfunction

  // Scoreboard monitor: every start/done/err pulse must match the front of
  // its queue, including the cycle it appears in.
  burst_t mb;
  err_t   me;
  always @(negedge clk) begin
    if (!rst) begin
      if (ub_read_start_out) begin
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected cyc=%0d addr=%0d num=%0d", cyc, ub_read_addr_out, ub_num_mem_locations_out);
        end else begin
          mb = start_q.pop_front();
          if ({ub_read_addr_out, ub_num_mem_locations_out, ub_row_or_col_out, owner_out} !== {mb.addr, mb.num, mb.rc, mb.own} || cyc != mb.scyc)
            begin
            errors++;
            $display("FAIL start_payload cyc=%0d addr=%0d num=%0d rc=%b own=%b expected cyc=%0d addr=%0d num=%0d rc=%b own=%b",
                     cyc, ub_read_addr_out, ub_num_mem_locations_out, ub_row_or_col_out, owner_out,
                     mb.scyc, mb.addr, mb.num, mb.rc, mb.own);
          end
        end
      end
      if (done_out !== 2'b00) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d done=%b", cyc, done_out);
        end else begin
          mb = done_q.pop_front();
          if (done_out !== (mb.own ? 2'b10 : 2'b01) || cyc != mb.dcyc) begin
            errors++;
            $display("FAIL done_pulse cyc=%0d done=%b expected cyc=%0d owner=%b", cyc, done_out, mb.dcyc, mb.own);
          end
        end
      end
      if (err_out !== 2'b00) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected cyc=%0d err=%b", cyc, err_out);
        end else begin
          me = err_q.pop_front();
          if (err_out !== (me.own ? 2'b10 : 2'b01) || cyc != me.ecyc) begin
            errors++;
            $display("FAIL err_pulse cyc=%0d err=%b expected cyc=%0d req=%b", cyc, err_out, me.ecyc, me.own);
          end
        end
      end
    end
  end

  // Wait for requester r to be ready, take the handshake, and record what
  // the DUT must produce. Returns at negedge+1 of the cycle after the edge.
  task automatic hs(input int r, output int e);
    int k;
    burst_t b;
    err_t x;
    logic [5:0] a;
    logic [5:0] n;
    k = 0;
    e = -1;
    while (req_ready_out[r] !== 1'b1 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (req_ready_out[r] !== 1'b1) begin
      errors++;
      $display("FAIL hs_timeout req=%0d ready=%b", r, req_ready_out);
    end else begin
      @(posedge clk); #1;
      e  = cyc;
      lg = r[0];
      a  = req_addr_in[r];
      n  = req_num_in[r];
      if (model_legal(a, n)) begin
        b.addr = a;
        b.num  = n;
        b.rc   = req_row_or_col_in[r];
        b.own  = r[0];
        b.scyc = e;
        b.dcyc = e + 1 + int'(n >> 1);
        start_q.push_back(b);
        done_q.push_back(b);
      end else begin
        x.own  = r[0];
        x.ecyc = e;
        err_q.push_back(x);
      end
      $display("txn req=%0d addr=%0d num=%0d legal=%b cyc=%0d", r, a, n, model_legal(a, n), e);
      @(negedge clk); #1;
    end
  endtask

  task automatic send(input int r, input logic [5:0] a, input logic [5:0] n, input logic rc, output int e);
    req_addr_in[r]       = a;
    req_num_in[r]        = n;
    req_row_or_col_in[r] = rc;
    req_valid_in[r]      = 1'b1;
    #1;
    hs(r, e);
    req_valid_in[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_out !== 1'b0 || start_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0) && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (busy_out !== 1'b0 || start_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b pending start=%0d done=%0d err=%0d",
               busy_out, start_q.size(), done_q.size(), err_q.size());
    end
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    start_q.delete();
    done_q.delete();
    err_q.delete();
    lg = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [19:0] all_outs();
    return {req_ready_out, ub_read_start_out, ub_read_addr_out, ub_num_mem_locations_out,
            ub_row_or_col_out, owner_out, busy_out, done_out, err_out};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (all_outs() !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", all_outs());
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_outs() !== 20'd0) begin
      errors++;
      $display("FAIL reset_held got=%h required=0", all_outs());
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    int e;
    send(0, 6'd4, 6'd4, 1'b1, e);
    for (int i = 0; i <= 3; i++) begin
      checks++;
      if (busy_out !== (i <= 2) || ub_read_start_out !== (i == 0) || err_out !== 2'b00) begin
        errors++;
        $display("FAIL single_timing off=%0d busy=%b start=%b err=%b required busy=%b start=%b err=00",
                 i, busy_out, ub_read_start_out, err_out, (i <= 2), (i == 0));
      end
      @(negedge clk); #1;
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int e0, e1;
    do_reset();
    req_addr_in[0] = 6'd10; req_num_in[0] = 6'd2; req_row_or_col_in[0] = 1'b0;
    req_addr_in[1] = 6'd20; req_num_in[1] = 6'd6; req_row_or_col_in[1] = 1'b1;
    req_valid_in = 2'b11;
    #1;
    checks++;
    if (req_ready_out !== 2'b01) begin
      errors++;
      $display("FAIL tie_after_reset ready=%b required=01", req_ready_out);
    end
    hs(0, e0);
    req_valid_in[0] = 1'b0;
    hs(1, e1);
    req_valid_in[1] = 1'b0;
    checks++;
    if (e1 - e0 != 3) begin
      errors++;
      $display("FAIL b2b_gap start_to_start=%0d required=3", e1 - e0);
    end
    wait_idle();
  endtask

  task automatic test_illegal_len();
    int e;
    req_addr_in[1] = 6'd5; req_num_in[1] = 6'd3; req_row_or_col_in[1] = 1'b0;
    req_valid_in[1] = 1'b1;
    #1;
    hs(1, e);
    checks++;
    if (err_out !== 2'b10 || ub_read_start_out !== 1'b0 || busy_out !== 1'b0 || req_ready_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_len err=%b start=%b busy=%b ready=%b required err=10 start=0 busy=0 ready=x1",
               err_out, ub_read_start_out, busy_out, req_ready_out);
    end
    req_valid_in[1] = 1'b0;
    wait_idle();
  endtask

  task automatic test_zero_len();
    int e;
    send(0, 6'd12, 6'd0, 1'b0, e);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_out !== 1'b0 || ub_read_start_out !== 1'b0 || err_out !== (i == 0 ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL zero_len off=%0d busy=%b start=%b err=%b required busy=0 start=0 err=%b",
                 i, busy_out, ub_read_start_out, err_out, (i == 0 ? 2'b01 : 2'b00));
      end
      @(negedge clk); #1;
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_burst();
    int e;
    send(0, 6'd8, 6'd8, 1'b1, e);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst_busy busy=%b required=1", busy_out);
    end
    rst = 1'b1;
    start_q.delete();
    done_q.delete();
    err_q.delete();
    lg = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h required=0", all_outs());
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    req_addr_in[0] = 6'd30; req_num_in[0] = 6'd2; req_row_or_col_in[0] = 1'b0;
    req_addr_in[1] = 6'd40; req_num_in[1] = 6'd4; req_row_or_col_in[1] = 1'b1;
    req_valid_in = 2'b11;
    #1;
    checks++;
    if (req_ready_out !== 2'b01) begin
      errors++;
      $display("FAIL tie_after_mid_reset ready=%b required=01", req_ready_out);
    end
    hs(0, e);
    req_valid_in[0] = 1'b0;
    hs(1, e);
    req_valid_in[1] = 1'b0;
    wait_idle();
  endtask

  task automatic test_round_robin();
    int e, k;
    int w;
    req_addr_in[0] = 6'd1; req_num_in[0] = 6'd2; req_row_or_col_in[0] = 1'b0;
    req_addr_in[1] = 6'd2; req_num_in[1] = 6'd2; req_row_or_col_in[1] = 1'b1;
    req_valid_in = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      w = lg ? 0 : 1;
      k = 0;
      while (req_ready_out === 2'b00 && k < 200) begin
        @(negedge clk); #1;
        k++;
      end
      checks++;
      if (req_ready_out !== (w == 1 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant round=%0d ready=%b required=%b", i, req_ready_out, (w == 1 ? 2'b10 : 2'b01));
      end
      hs(w, e);
      req_addr_in[w] = req_addr_in[w] + 6'd4;
    end
    req_valid_in = 2'b00;
    wait_idle();
  endtask

  task automatic test_bounds();
    int e;
    logic exp_start;
    exp_start = model_legal(6'd48, 6'd4);
    send(0, 6'd48, 6'd4, 1'b0, e);
    checks++;
    if (ub_read_start_out !== exp_start || err_out !== (exp_start ? 2'b00 : 2'b01)) begin
      errors++;
      $display("FAIL bounds_over start=%b err=%b required start=%b err=%b",
               ub_read_start_out, err_out, exp_start, (exp_start ? 2'b00 : 2'b01));
    end
    wait_idle();
    send(1, 6'd46, 6'd4, 1'b1, e);
    checks++;
    if (ub_read_start_out !== 1'b1 || err_out !== 2'b00) begin
      errors++;
      $display("FAIL bounds_edge start=%b err=%b required start=1 err=00", ub_read_start_out, err_out);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal_len();
    test_zero_len();
    test_reset_mid_burst();
    test_round_robin();
    test_bounds();
    checks++;
    if (start_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL leftover start=%0d done=%0d err=%0d required 0", start_q.size(), done_q.size(), err_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
